// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD front end and digit scanner for a 4-digit FND.
// Converts a 0..9999 value with a sequential double-dabble and time-multiplexes the digits.
module fnd_scan_controller #(
  parameter int unsigned CLK_DIV       = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic [13:0] i_value,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_bcd,
  output logic        o_fndEn,
  output logic        o_busy
);

  localparam int unsigned PreW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);
  localparam logic [13:0] MaxValue = 14'd9999;
  localparam logic [3:0] ShiftCount = 4'd14;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [PreW-1:0] pre_q, pre_d;
  logic [1:0]      digit_q, digit_d;
  logic            tick;

  logic [15:0] disp_q, disp_d;
  logic [15:0] scratch_q, scratch_d;
  logic [15:0] scratch_adj;
  logic [13:0] bin_q, bin_d;
  logic [3:0]  shift_cnt_q, shift_cnt_d;
  logic        accept;
  logic        blank;

  // Scan prescaler and digit counter: both hold while the display is disabled.
  always_comb begin
    tick    = i_en && (pre_q == PreMax);
    pre_d   = pre_q;
    digit_d = digit_q;
    if (i_en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (tick) begin
      digit_d = digit_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q   <= '0;
      digit_q <= 2'd0;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
    end
  end

  // Converter FSM: state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Converter FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_valid) state_d = StShift;
      StShift: if (shift_cnt_q == 4'd1) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Converter FSM: outputs.
  always_comb begin
    o_ready = (state_q == StIdle);
    o_busy  = (state_q != StIdle);
  end

  assign accept = i_valid && o_ready;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    shift_cnt_d = shift_cnt_q;
    disp_d      = disp_q;
    if (accept) begin
      bin_d       = (i_value > MaxValue) ? MaxValue : i_value;
      scratch_d   = 16'h0000;
      shift_cnt_d = ShiftCount;
    end else if (state_q == StShift) begin
      {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
      shift_cnt_d        = shift_cnt_q - 4'd1;
    end
    // The display only ever sees a finished conversion.
    if (state_q == StDone) begin
      disp_d = scratch_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bin_q       <= 14'd0;
      scratch_q   <= 16'h0000;
      shift_cnt_q <= 4'd0;
      disp_q      <= 16'h0000;
    end else begin
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      shift_cnt_q <= shift_cnt_d;
      disp_q      <= disp_d;
    end
  end

  // Leading-zero blanking: digit d is blank when it and every higher nibble are zero.
  always_comb begin
    blank = 1'b0;
    if (BLANK_LEADING) begin
      unique case (digit_q)
        2'd0: blank = 1'b0;
        2'd1: blank = (disp_q[15:4] == 12'h000);
        2'd2: blank = (disp_q[15:8] == 8'h00);
        2'd3: blank = (disp_q[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    o_digitSelect = digit_q;
    o_bcd         = disp_q[{digit_q, 2'b00} +: 4];
    o_fndEn       = i_en & ~blank;
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Upstream driver for the 4-digit FND path. It accepts a binary value (0-9999) over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits. Each scan step presents a 2-bit digit index to FND_Select_Decoder and the matching 4-bit BCD code to BCDtoFNDdecoder, plus a decoder enable that blanks leading zeros.

Parameters:
CLK_DIV, 100000, scan prescaler period in clocks per digit (1 kHz/digit at 100 MHz); legal range >= 2
BLANK_LEADING, 1, 1 = suppress leading zeros on digits 3..1; 0 = show all digits

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous active-low reset
i_en  input  1  display enable; low freezes scanning and blanks output
i_value  input  14  binary value to display
i_valid  input  1  i_value is valid this cycle
o_ready  output  1  converter idle, can accept a value
o_digitSelect  output  2  current digit index (0 = ones … 3 = thousands) -> FND_Select_Decoder.i_digitSelect
o_bcd  output  4  BCD code of current digit -> BCDtoFNDdecoder.i_value
o_fndEn  output  1  decoder enable -> i_en of both decoders
o_busy  output  1  conversion in progress

Behaviour:
- Reset (async assert, sync release): prescaler = 0, digit counter = 0, display register = 16'h0000, FSM = IDLE. Outputs: o_digitSelect = 0, o_bcd = 0, o_busy = 0, o_ready = 1, o_fndEn = i_en.
- Prescaler: counts 0..CLK_DIV-1 only while i_en = 1 and wraps to 0. A tick is issued on the cycle it equals CLK_DIV-1.
- Digit counter: increments on each tick and wraps 3 -> 0. It holds while i_en = 0, and so does the prescaler; neither resets.
- o_digitSelect = digit counter, registered.
- o_bcd = display register nibble [4*d+3:4*d] for d = digit counter.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: o_ready = 1. A handshake occurs when i_valid & o_ready on a rising edge. On that edge, capture i_value, saturating values > 9999 to 9999, clear the BCD scratch register, load shift count 14, and go to SHIFT.
  - SHIFT: 14 cycles. Each cycle, every scratch nibble >= 5 gets +3, then {scratch, binary} is shifted left by 1. After the 14th shift, go to DONE.
  - DONE: 1 cycle. Copy scratch to the display register, then go to IDLE.
- o_busy = (state != IDLE); o_ready = (state == IDLE).
- Latency: accept on edge k; new digits are visible on o_bcd after edge k+15. Next acceptance is possible at edge k+16.
- Until DONE, the display register keeps the old value, so the display never shows a partial result.
- i_valid while busy is ignored. The producer holds i_value/i_valid until o_ready.
- Arithmetic: the scratch register is 16 bits (4 nibbles); all intermediate values fit, so there is no overflow.
- Blanking (BLANK_LEADING = 1): digit d is blank when d > 0 and all display nibbles at indices >= d are zero. Digit 0 is never blanked, so value 0 shows "0".
- o_fndEn = i_en & ~blank(current digit), combinational from registers.
- Conversion runs regardless of i_en.
- Reset asserted mid-conversion: the conversion aborts, the display register returns to 0, and the FSM returns to IDLE.
- Simultaneous tick and DONE: the digit counter advances, and o_bcd shows the new digit's nibble from the new display value.

Test Plan:
- Reset check (CLK_DIV=4): hold i_reset_n = 0 for 3 cycles -> o_digitSelect = 0, o_bcd = 0, o_ready = 1, o_busy = 0; after release with i_en = 1, o_digitSelect steps 0,1,2,3,0 every 4 clocks.
- Conversion: send i_value = 1234 with i_valid for 1 cycle -> o_ready low for 15 cycles, then display = 16'h1234. The scan shows o_bcd 4,3,2,1 for o_digitSelect 0,1,2,3, with o_fndEn = 1 throughout.
- Blanking: send i_value = 7 -> digit 0 o_bcd = 7, o_fndEn = 1; digits 1..3 o_fndEn = 0. Send i_value = 0 -> only digit 0 is enabled, o_bcd = 0. Send 1005 -> all four digits are enabled (inner zeros are kept).
- Saturation and busy: send i_value = 14'h3FFF -> display 9999. While busy, present i_value = 42 with i_valid high -> not accepted until o_ready = 1, then 42 is displayed.
- Enable gating: set i_en = 0 mid-scan for 20 cycles -> o_digitSelect frozen, o_fndEn = 0; on re-enable, scanning resumes from the frozen digit.
- Async reset mid-conversion: assert i_reset_n = 0 at cycle 5 of SHIFT for 8888 -> immediate o_busy = 0; display stays 0 and never shows 8888.
